// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Round-robin arbiter sharing one 512x8 SRAM macro between NUM_REQ
//   requesters. The macro pins are driven combinationally from the current
//   grant; read data returns one cycle after an accepted read, tagged by a
//   one-hot rsp_valid.
//
// Optional feature (macro SRAM_ARB_LOCK_EN):
//   Adds req_lock. A transfer with req_lock set makes that requester the lock
//   owner; only the owner can be granted until it transfers with req_lock=0.
//
// Ports:
//   clk, rst_n            clock (also the macro clock), sync active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_we                1=write, 0=read
//   req_addr/wdata/wmask  packed per-requester address, data, bit enables
//   req_lock              (SRAM_ARB_LOCK_EN only) hold the grant
//   rsp_valid/rsp_rdata   one-hot read response, shared data bus
//   sram_cen/gwen/wen/a/d macro control and write pins (active-low enables)
//   sram_q                macro read data

module sram_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
`ifdef SRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*DATA_W-1:0] req_wmask,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      sram_cen,
    output logic                      sram_gwen,
    output logic [DATA_W-1:0]         sram_wen,
    output logic [ADDR_W-1:0]         sram_a,
    output logic [DATA_W-1:0]         sram_d,
    input  logic [DATA_W-1:0]         sram_q
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   grant_idx;
    logic               granted;
    logic [NUM_REQ-1:0] rsp_next;

`ifdef SRAM_ARB_LOCK_EN
    typedef enum logic {
        LOCK_NONE,
        LOCK_HELD
    } lock_state_t;

    lock_state_t        lock_state;
    lock_state_t        lock_state_next;
    logic [PTR_W-1:0]   lock_owner;
    logic [PTR_W-1:0]   lock_owner_next;
`endif

    // Rotating priority split into two linear passes: indices at or above
    // ptr first, then the ones below it, which is the same order as scanning
    // ptr, ptr+1, ... modulo NUM_REQ.
    always_comb begin
        granted   = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!granted && req_valid[i] && i >= 32'(ptr)) begin
                granted   = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!granted && req_valid[i] && i < 32'(ptr)) begin
                granted   = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
`ifdef SRAM_ARB_LOCK_EN
        // A held lock overrides the scan; an idle owner blocks everyone.
        if (lock_state == LOCK_HELD) begin
            granted   = req_valid[lock_owner];
            grant_idx = lock_owner;
        end
`endif
        if (!rst_n) begin
            granted = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        rsp_next  = '0;
        ptr_next  = ptr;
`ifdef SRAM_ARB_LOCK_EN
        lock_state_next = lock_state;
        lock_owner_next = lock_owner;
`endif
        if (granted) begin
            req_ready[grant_idx] = 1'b1;
            sram_cen = 1'b0;
            sram_a   = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            if (req_we[grant_idx]) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask[int'(grant_idx)*DATA_W +: DATA_W];
                sram_d    = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            end else begin
                rsp_next[grant_idx] = 1'b1;
            end
            ptr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
`ifdef SRAM_ARB_LOCK_EN
            if (req_lock[grant_idx]) begin
                lock_state_next = LOCK_HELD;
                lock_owner_next = grant_idx;
                ptr_next        = ptr;
            end else begin
                lock_state_next = LOCK_NONE;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= '0;
        end else begin
            ptr       <= ptr_next;
            rsp_valid <= rsp_next;
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_state <= LOCK_NONE;
            lock_owner <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_owner <= lock_owner_next;
        end
    end
`endif

    always_comb begin
        rsp_rdata = (|rsp_valid) ? sram_q : '0;
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter
//   Directed bench for sram_rr_arbiter with NUM_REQ=2 and a behavioural
//   512x8 macro model (one-cycle read latency, active-low bit write enables).

module tb_sram_rr_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] req_wmask;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        sram_cen;
    logic        sram_gwen;
    logic [7:0]  sram_wen;
    logic [8:0]  sram_a;
    logic [7:0]  sram_d;
    logic [7:0]  sram_q = '0;
`ifdef SRAM_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:511];

    sram_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
`ifdef SRAM_ARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .sram_cen (sram_cen),
        .sram_gwen(sram_gwen),
        .sram_wen (sram_wen),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q)
    );

    always #5 clk = ~clk;

    // Macro model
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mem[sram_a];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [8:0] addr,
                           input logic [7:0] wd, input logic [7:0] mask);
        req_we[i]             = we;
        req_addr[i*9 +: 9]    = addr;
        req_wdata[i*8 +: 8]   = wd;
        req_wmask[i*8 +: 8]   = mask;
    endtask

    task automatic idle_all;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
`ifdef SRAM_ARB_LOCK_EN
        req_lock  = '0;
`endif
    endtask

    task automatic reset_dut;
        idle_all();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_all();
        req_valid = 2'b11;
        set_req(0, 1'b1, 9'h055, 8'hAA, 8'hFF);
        set_req(1, 1'b0, 9'h0AA, 8'h55, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
            checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL reset_cen: got %b expected 1", sram_cen); end
            checks++; if (sram_gwen !== 1'b1) begin errors++; $display("FAIL reset_gwen: got %b expected 1", sram_gwen); end
            checks++; if (sram_wen !== 8'hFF) begin errors++; $display("FAIL reset_wen: got %h expected ff", sram_wen); end
            checks++; if (sram_a !== 9'h000) begin errors++; $display("FAIL reset_a: got %h expected 000", sram_a); end
            checks++; if (sram_d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h expected 00", sram_d); end
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        end
        idle_all();
        rst_n = 1'b1;
        tick();
        checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL idle_cen: got %b expected 1", sram_cen); end
    endtask

    task automatic test_write_read;
        reset_dut();
        set_req(0, 1'b1, 9'h1A5, 8'h3C, 8'hFF);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
        checks++; if (sram_cen !== 1'b0) begin errors++; $display("FAIL wr_cen: got %b expected 0", sram_cen); end
        checks++; if (sram_gwen !== 1'b0) begin errors++; $display("FAIL wr_gwen: got %b expected 0", sram_gwen); end
        checks++; if (sram_wen !== 8'h00) begin errors++; $display("FAIL wr_wen: got %h expected 00", sram_wen); end
        checks++; if (sram_a !== 9'h1A5) begin errors++; $display("FAIL wr_a: got %h expected 1a5", sram_a); end
        checks++; if (sram_d !== 8'h3C) begin errors++; $display("FAIL wr_d: got %h expected 3c", sram_d); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b expected 00", rsp_valid); end
        set_req(0, 1'b0, 9'h1A5, 8'h00, 8'h00);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
        checks++; if (sram_gwen !== 1'b1) begin errors++; $display("FAIL rd_gwen: got %b expected 1", sram_gwen); end
        checks++; if (sram_wen !== 8'hFF) begin errors++; $display("FAIL rd_wen: got %h expected ff", sram_wen); end
        tick();
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata: got %h expected 3c", rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_pulse: got %b expected 00", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rd_rdata_idle: got %h expected 00", rsp_rdata); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_r;
        logic [8:0] exp_a;
        logic [7:0] exp_d;
        reset_dut();
        mem[9'h020] = 8'hA0;
        mem[9'h031] = 8'hB1;
        set_req(0, 1'b0, 9'h020, 8'h00, 8'h00);
        set_req(1, 1'b0, 9'h031, 8'h00, 8'h00);
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (c % 2 == 0) ? 9'h020 : 9'h031;
            exp_d = (c % 2 == 0) ? 8'hA0 : 8'hB1;
            #1;
            checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, exp_r); end
            checks++; if (sram_a !== exp_a) begin errors++; $display("FAIL rr_a[%0d]: got %h expected %h", c, sram_a, exp_a); end
            tick();
            checks++; if (rsp_valid !== exp_r) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, exp_r); end
            checks++; if (rsp_rdata !== exp_d) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", c, rsp_rdata, exp_d); end
        end
        req_valid = 2'b00;
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rr_rsp_end: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_partial_write;
        req_valid = 2'b10;
        set_req(1, 1'b1, 9'h010, 8'hFF, 8'hFF);
        tick();
        set_req(1, 1'b1, 9'h010, 8'h00, 8'h0F);
        #1;
        checks++; if (sram_wen !== 8'hF0) begin errors++; $display("FAIL pw_wen: got %h expected f0", sram_wen); end
        tick();
        set_req(1, 1'b1, 9'h010, 8'h55, 8'h00);
        #1;
        checks++; if (sram_cen !== 1'b0) begin errors++; $display("FAIL pw_zero_cen: got %b expected 0", sram_cen); end
        checks++; if (sram_gwen !== 1'b0) begin errors++; $display("FAIL pw_zero_gwen: got %b expected 0", sram_gwen); end
        checks++; if (sram_wen !== 8'hFF) begin errors++; $display("FAIL pw_zero_wen: got %h expected ff", sram_wen); end
        tick();
        set_req(1, 1'b0, 9'h010, 8'h00, 8'h00);
        tick();
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL pw_rsp_valid: got %b expected 10", rsp_valid); end
        checks++; if (rsp_rdata !== 8'hF0) begin errors++; $display("FAIL pw_rdata: got %h expected f0", rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read;
        // req0 read moves ptr to 1 so the post-reset grant shows ptr cleared
        set_req(0, 1'b0, 9'h020, 8'h00, 8'h00);
        set_req(1, 1'b0, 9'h031, 8'h00, 8'h00);
        req_valid = 2'b01;
        tick();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rm_pre_rsp: got %b expected 01", rsp_valid); end
        checks++; if (rsp_rdata !== 8'hA0) begin errors++; $display("FAIL rm_pre_rdata: got %h expected a0", rsp_rdata); end
        req_valid = 2'b10;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rm_ready: got %b expected 00", req_ready); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_valid: got %b expected 00", rsp_valid); end
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b expected 01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rm_post_rsp: got %b expected 01", rsp_valid); end
        tick();
    endtask

`ifdef SRAM_ARB_LOCK_EN
    task automatic test_lock;
        reset_dut();
        set_req(0, 1'b1, 9'h100, 8'h11, 8'hFF);
        set_req(1, 1'b1, 9'h101, 8'h22, 8'hFF);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        req_lock  = 2'b10;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) req_lock = 2'b00;
            #1;
            checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_stall[%0d]: got %b expected 10", c, req_ready); end
            tick();
        end
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_release: got %b expected 01", req_ready); end
        tick();
        req_valid = 2'b10;
        req_lock  = 2'b10;
        tick();
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL lock_owner_idle: got %b expected 00", req_ready); end
        tick();
        req_valid = 2'b11;
        req_lock  = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_unlock_xfer: got %b expected 10", req_ready); end
        tick();
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_after: got %b expected 01", req_ready); end
        tick();
        idle_all();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 8'h00;
        test_reset();
        test_write_read();
        test_round_robin();
        test_partial_write();
        test_reset_mid_read();
`ifdef SRAM_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
